// File: rtl/accum_share_ctrl.sv
// accum_share_ctrl: round-robin sequencer for one shared accumulator.
// A granted requester streams a burst into the sum register.
// The final sum is then offered, tagged with its owner, on a valid/ready handshake.
//
// Handshakes: a word on lane i moves when InValid[i] & InReady[i] at a rising
// edge; the result moves when SumValid & SumReady at a rising edge. Neither
// ready/valid output depends combinationally on the opposite side's input.
module accum_share_ctrl #(
  parameter int WIDTH  = 4,
  parameter int NREQ   = 4,
  parameter int MAXLEN = 8
) (
  input  logic                     Clock,
  input  logic                     Reset,
  input  logic [NREQ-1:0]          Req,
  input  logic [NREQ-1:0]          InValid,
  input  logic [NREQ*WIDTH-1:0]    InData,
  input  logic [NREQ-1:0]          InLast,
  output logic [NREQ-1:0]          InReady,
  output logic [NREQ-1:0]          Grant,
  output logic [WIDTH-1:0]         SumOut,
  output logic [$clog2(NREQ)-1:0]  SumOwner,
  output logic                     SumValid,
  input  logic                     SumReady,
  output logic                     Overflow,
  output logic [1:0]               fsm_state
);

  localparam int OWN_W = $clog2(NREQ);
  localparam int CNT_W = $clog2(MAXLEN + 1);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ACCUM = 2'd1,
    ST_DONE  = 2'd2
  } state_t;

  state_t             state;
  state_t             state_next;
  logic [OWN_W-1:0]   owner;
  logic [OWN_W-1:0]   ptr;
  logic [OWN_W-1:0]   winner;
  logic [WIDTH-1:0]   reg_sum;
  logic [CNT_W-1:0]   count;
  logic               ovf;
  logic [WIDTH-1:0]   lane_data;
  logic               lane_valid;
  logic               lane_last;
  logic               accept;
  logic               burst_end;
  logic [WIDTH:0]     sum_ext;

  // First set request bit searching upward from the pointer, wrapping at NREQ.
  function automatic logic [OWN_W-1:0] rr_pick(input logic [NREQ-1:0] r,
                                               input logic [OWN_W-1:0] p);
    logic [OWN_W-1:0] pick;
    logic             found;
    int               idx;
    pick  = '0;
    found = 1'b0;
    for (int i = 0; i < NREQ; i++) begin
      idx = int'(p) + i;
      if (idx >= NREQ) idx = idx - NREQ;
      if (!found && r[idx]) begin
        found = 1'b1;
        pick  = OWN_W'(idx);
      end
    end
    return pick;
  endfunction

  // Only the owner's lane is observed; every other lane is ignored.
  assign winner     = rr_pick(Req, ptr);
  assign lane_data  = InData[int'(owner)*WIDTH +: WIDTH];
  assign lane_valid = InValid[owner];
  assign lane_last  = InLast[owner];
  assign accept     = (state == ST_ACCUM) && lane_valid;
  assign burst_end  = accept && (lane_last || (count == CNT_W'(MAXLEN - 1)));
  assign sum_ext    = {1'b0, reg_sum} + {1'b0, lane_data};

  // State register.
  always_ff @(posedge Clock) begin
    if (Reset) state <= ST_IDLE;
    else       state <= state_next;
  end

  // Next-state logic; arbitration happens only in IDLE.
  always_comb begin
    state_next = state;
    case (state)
      ST_IDLE:  if (|Req)     state_next = ST_ACCUM;
      ST_ACCUM: if (burst_end) state_next = ST_DONE;
      ST_DONE:  if (SumReady)  state_next = ST_IDLE;
      default:                 state_next = ST_IDLE;
    endcase
  end

  // Datapath: owner capture, accumulation, sticky carry, burst count, RR pointer.
  always_ff @(posedge Clock) begin
    if (Reset) begin
      owner   <= '0;
      ptr     <= '0;
      reg_sum <= '0;
      count   <= '0;
      ovf     <= 1'b0;
    end else begin
      if (state == ST_IDLE && |Req) begin
        owner   <= winner;
        reg_sum <= '0;
        count   <= '0;
        ovf     <= 1'b0;
      end
      if (accept) begin
        reg_sum <= sum_ext[WIDTH-1:0];
        ovf     <= ovf | sum_ext[WIDTH];
        count   <= count + CNT_W'(1);
      end
      if (state == ST_DONE && SumReady) begin
        ptr <= (owner == OWN_W'(NREQ - 1)) ? '0 : owner + OWN_W'(1);
      end
    end
  end

  // Output decode from registered state only.
  always_comb begin
    Grant    = '0;
    InReady  = '0;
    SumValid = 1'b0;
    if (state == ST_ACCUM) begin
      Grant[owner]   = 1'b1;
      InReady[owner] = 1'b1;
    end
    if (state == ST_DONE) SumValid = 1'b1;
  end

  // Result fields hold in DONE because nothing writes them until the next grant.
  assign SumOut    = reg_sum;
  assign SumOwner  = owner;
  assign Overflow  = ovf;
  assign fsm_state = state;

endmodule
